fir_serial_mac: RTL and testbench

FIR_SERIAL_MAC -- requirements
Module: fir_serial_mac

---
 rtl/fir_serial_mac.sv | 196 +++++++++++++++++++
 tb/tb_fir_serial_mac.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_serial_mac.sv
// ---------------------------------------------------------------------------
// fir_serial_mac
//   Time-multiplexed direct-form FIR filter.  Each accepted sample is written
//   into an NTAPS-deep circular history buffer.  A single shared multiplier
//   then accumulates coef[k] * x[n-k] for k = 0..NTAPS-1, one tap per cycle.
//   The scaled and reduced sum is held on y_out until the consumer takes it.
//
//   Build option: define FIR_ROUND_SAT_EN to round half-up and saturate the
//   shifted accumulator.  When it is undefined, the shifted value is
//   truncated to OW bits (two's-complement wrap).
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears state, history, coefs)
//   in_valid   sample offered            in_ready  high only while IDLE
//   in_data    signed sample (DW)
//   out_valid  y_out holds a result      out_ready downstream accepts result
//   y_out      signed filter result (OW)
//   coef_we    coefficient write strobe (honoured only while IDLE)
//   coef_addr  coefficient index k      coef_data signed coefficient (CW)
//   busy       high whenever not IDLE
// ---------------------------------------------------------------------------
module fir_serial_mac #(
    parameter int NTAPS = 63,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int OW    = 32,
    parameter int SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DW-1:0]     in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OW-1:0]     y_out,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic signed [CW-1:0]     coef_data,
    output logic                     busy
);

    localparam int IW = $clog2(NTAPS);
    localparam int PW = DW + CW;
    localparam int AW = DW + CW + $clog2(NTAPS);
    // Working width for reduction: room for the rounding carry and for OW > AW.
    localparam int EW = ((AW + 1 > OW) ? AW + 1 : OW) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);
`ifdef FIR_ROUND_SAT_EN
    // Bit position of the first discarded bit; only meaningful when SHIFT > 0.
    localparam int RB = (SHIFT > 0) ? SHIFT - 1 : 0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // Scale the accumulator by SHIFT and reduce it to the output width.
    function automatic logic signed [OW-1:0] reduce_acc(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] shifted;
        logic signed [EW-1:0] ext;
        logic signed [OW-1:0] res;
`ifdef FIR_ROUND_SAT_EN
        logic signed [EW-1:0] smax;
        logic signed [EW-1:0] smin;
        logic                 round_bit;
`endif
        shifted = acc >>> SHIFT;
        ext     = {{(EW-AW){shifted[AW-1]}}, shifted};
`ifdef FIR_ROUND_SAT_EN
        smax      = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
        smin      = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};
        round_bit = (SHIFT > 0) ? acc[RB] : 1'b0;
        // Half-up: adding the first dropped bit rounds ties toward +infinity.
        ext = ext + {{(EW-1){1'b0}}, round_bit};
        if (ext > smax) begin
            res = OW'(smax);
        end else if (ext < smin) begin
            res = OW'(smin);
        end else begin
            res = OW'(ext);
        end
`else
        res = OW'(ext);
`endif
        return res;
    endfunction

    state_t                 state_q, state_d;
    logic signed [DW-1:0]   x_q    [NTAPS];
    logic signed [DW-1:0]   x_d    [NTAPS];
    logic signed [CW-1:0]   coef_q [NTAPS];
    logic signed [CW-1:0]   coef_d [NTAPS];
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [IW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [IW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]          tap_q, tap_d;
    logic signed [OW-1:0]   y_out_q, y_out_d;
    logic signed [PW-1:0]   prod_s;
    logic signed [AW-1:0]   sum_s;

    // Next-state, datapath and buffer-update logic.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        coef_d   = coef_q;
        acc_d    = acc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        tap_d    = tap_q;
        y_out_d  = y_out_q;

        // The single shared multiplier; the sum cannot overflow in AW bits.
        prod_s = coef_q[tap_q] * x_q[rd_ptr_q];
        sum_s  = acc_q + {{(AW-PW){prod_s[PW-1]}}, prod_s};

        case (state_q)
            S_IDLE: begin
                // Coef writes land before the MAC pass, so a write in the
                // accepting cycle already applies to that sample.
                if (coef_we && (int'(coef_addr) < NTAPS)) begin
                    coef_d[coef_addr] = coef_data;
                end else begin
                    coef_d = coef_q;
                end
                if (in_valid) begin
                    x_d[wr_ptr_q] = in_data;
                    acc_d         = {AW{1'b0}};
                    rd_ptr_d      = wr_ptr_q;
                    tap_d         = {IW{1'b0}};
                    wr_ptr_d      = (wr_ptr_q == LAST_IDX) ? {IW{1'b0}} : wr_ptr_q + IW'(1);
                    state_d       = S_MAC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MAC: begin
                acc_d = sum_s;
                // Walk backwards through history: newest sample pairs with k=0.
                rd_ptr_d = (rd_ptr_q == {IW{1'b0}}) ? LAST_IDX : rd_ptr_q - IW'(1);
                if (tap_q == LAST_IDX) begin
                    tap_d   = {IW{1'b0}};
                    y_out_d = reduce_acc(sum_s);
                    state_d = S_OUT;
                end else begin
                    tap_d   = tap_q + IW'(1);
                    state_d = S_MAC;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, history, coefficient and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= {AW{1'b0}};
            wr_ptr_q <= {IW{1'b0}};
            rd_ptr_q <= {IW{1'b0}};
            tap_q    <= {IW{1'b0}};
            y_out_q  <= {OW{1'b0}};
            for (int i = 0; i < NTAPS; i++) begin
                x_q[i]    <= {DW{1'b0}};
                coef_q[i] <= {CW{1'b0}};
            end
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tap_q    <= tap_d;
            y_out_q  <= y_out_d;
            x_q      <= x_d;
            coef_q   <= coef_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign y_out     = y_out_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
// ---------------------------------------------------------------------------
// tb_fir_serial_mac
//   Directed, self-checking bench.  Main instance uses default parameters
//   (63 taps, SHIFT 0); a small second instance (4 taps, SHIFT 4) covers the
//   rounding/truncation boundary.  Inputs change on the falling edge and
//   outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_fir_serial_mac;

    localparam int NT = 63;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid, in_ready, out_valid, out_ready, busy, coef_we;
    logic signed [15:0] in_data, coef_data;
    logic signed [31:0] y_out;
    logic [5:0]         coef_addr;

    logic               s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy, s_coef_we;
    logic signed [15:0] s_in_data, s_coef_data;
    logic signed [31:0] s_y_out;
    logic [1:0]         s_coef_addr;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic signed [15:0] x;
        longint             y;
    } vec_t;
    vec_t vt [5];

    always #5 clk = ~clk;

    fir_serial_mac u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .y_out(y_out), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .busy(busy)
    );

    fir_serial_mac #(.NTAPS(4), .SHIFT(4)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .y_out(s_y_out), .coef_we(s_coef_we), .coef_addr(s_coef_addr),
        .coef_data(s_coef_data), .busy(s_busy)
    );

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic write_coef(input int k, input logic signed [15:0] v);
        coef_we   = 1'b1;
        coef_addr = 6'(k);
        coef_data = v;
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    // Offer one sample in IDLE and collect its result.  Optional extras: a
    // coef[0] write in the accepting cycle, a coef[0]=5 write attempt during
    // MAC, and an out_ready stall with in_valid held high.
    task automatic send_sample(input logic signed [15:0] x, input bit chk, input longint exp_y,
                               input string nm, input int stall, input bit busy_we,
                               input bit same_we, input logic signed [15:0] same_val);
        int cyc;
        in_valid = 1'b1;
        in_data  = x;
        if (same_we) begin
            coef_we   = 1'b1;
            coef_addr = 6'd0;
            coef_data = same_val;
        end
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        if (chk) begin
            check({nm, " busy"}, longint'(busy), 1);
            check({nm, " in_ready low"}, longint'(in_ready), 0);
        end
        if (busy_we) begin
            coef_we   = 1'b1;
            coef_addr = 6'd0;
            coef_data = 16'sd5;
        end
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            coef_we = 1'b0;
            cyc++;
        end
        coef_we = 1'b0;
        // Cycles counted from the offering cycle to the first out_valid cycle.
        check({nm, " latency"}, longint'(cyc), longint'(NT + 1));
        if (chk) check({nm, " y_out"}, longint'(y_out), exp_y);
        if (stall > 0) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 16'sd1000;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check({nm, " stall out_valid"}, longint'(out_valid), 1);
                check({nm, " stall y_out"}, longint'(y_out), exp_y);
                check({nm, " stall in_ready"}, longint'(in_ready), 0);
            end
            out_ready = 1'b1;
            in_valid  = 1'b0;
        end
        @(negedge clk);
        if (chk) begin
            check({nm, " back to idle"}, longint'(in_ready), 1);
            check({nm, " out_valid dropped"}, longint'(out_valid), 0);
        end
    endtask

    task automatic s_send(input logic signed [15:0] x, input longint exp_y, input string nm);
        int cyc;
        s_in_valid = 1'b1;
        s_in_data  = x;
        @(negedge clk);
        s_in_valid = 1'b0;
        cyc = 1;
        while (!s_out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, " latency"}, longint'(cyc), 5);
        check({nm, " y_out"}, longint'(s_y_out), exp_y);
        @(negedge clk);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov_seen;
        // Expected outputs with coef[k] = k+1 and all-zero history.
        vt[0] = '{16'sd1,      1};
        vt[1] = '{16'sd2,      4};
        vt[2] = '{-16'sd3,     4};
        vt[3] = '{16'sd100,    104};
        vt[4] = '{-16'sd32768, -32564};

        rst_n = 1'b0;
        in_valid = 1'b0; in_data = 16'sd0; out_ready = 1'b1;
        coef_we = 1'b0; coef_addr = 6'd0; coef_data = 16'sd0;
        s_in_valid = 1'b0; s_in_data = 16'sd0; s_out_ready = 1'b1;
        s_coef_we = 1'b0; s_coef_addr = 2'd0; s_coef_data = 16'sd0;
        #1;
        check("reset out_valid", longint'(out_valid), 0);
        check("reset busy", longint'(busy), 0);
        check("reset y_out", longint'(y_out), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset in_ready", longint'(in_ready), 1);

        // Impulse response: y = 1..63.
        for (int k = 0; k < NT; k++) write_coef(k, 16'(k + 1));
        for (int i = 0; i < NT; i++)
            send_sample((i == 0) ? 16'sd1 : 16'sd0, 1'b1, longint'(i + 1), "impulse", 0, 1'b0, 1'b0, 16'sd0);

        // Table vectors; the impulse has just been overwritten by the wrap.
        for (int i = 0; i < 5; i++)
            send_sample(vt[i].x, 1'b1, vt[i].y, "table", 0, 1'b0, 1'b0, 16'sd0);

        // Full-scale accumulation.
        for (int k = 0; k < NT; k++) write_coef(k, 16'sd32767);
        for (int i = 0; i < NT; i++)
`ifdef FIR_ROUND_SAT_EN
            send_sample(16'sd32767, (i == NT - 1), 64'sd2147483647, "full scale", 0, 1'b0, 1'b0, 16'sd0);
`else
            send_sample(16'sd32767, (i == NT - 1), -64'sd1077870529, "full scale", 0, 1'b0, 1'b0, 16'sd0);
`endif

        // Reset mid-MAC.
        in_valid = 1'b1; in_data = 16'sd500;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", longint'(out_valid), 0);
        check("abort busy", longint'(busy), 0);
        check("abort in_ready", longint'(in_ready), 1);
        check("abort y_out", longint'(y_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        check("aborted sample never valid", longint'(ov_seen), 0);
        send_sample(16'sd7, 1'b1, 0, "coefs cleared", 0, 1'b0, 1'b0, 16'sd0);
        for (int k = 0; k < NT; k++) write_coef(k, 16'sd1);
        send_sample(16'sd0, 1'b1, 7, "buffer cleared", 0, 1'b0, 1'b0, 16'sd0);
        for (int k = 0; k < NT; k++) write_coef(k, 16'(k + 1));
        // History now: 7 at age 1 then 0 at age 0 -> shift in impulse.
        send_sample(16'sd1, 1'b1, 1 + 2*0 + 3*7, "fresh impulse 0", 0, 1'b0, 1'b0, 16'sd0);
        send_sample(16'sd0, 1'b1, 2 + 4*7, "fresh impulse 1", 0, 1'b0, 1'b0, 16'sd0);

        // Busy-time coef write, output stall, same-cycle coef write.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        write_coef(0, 16'sd7);
        write_coef(1, 16'sd3);
        write_coef(63, 16'sd9);
        send_sample(16'sd0, 1'b1, 0, "busy write", 10, 1'b1, 1'b0, 16'sd0);
        send_sample(16'sd1, 1'b1, 7, "old coef0 kept", 0, 1'b0, 1'b0, 16'sd0);
        send_sample(16'sd1, 1'b1, 5 + 3, "same-cycle coef", 0, 1'b0, 1'b1, 16'sd5);

        // SHIFT=4 boundary: 24/16 = 1.5 and -24/16 = -1.5.
        s_coef_we = 1'b1; s_coef_addr = 2'd0; s_coef_data = 16'sd1;
        @(negedge clk);
        s_coef_we = 1'b0;
`ifdef FIR_ROUND_SAT_EN
        s_send(16'sd24, 2, "shift4 +1.5");
        s_send(-16'sd24, -1, "shift4 -1.5");
`else
        s_send(16'sd24, 1, "shift4 +1.5");
        s_send(-16'sd24, -2, "shift4 -1.5");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
